dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised byte-addressable data memory with a RISC-V load/store front end for the single-cycle core's memory stage and its multi-cycle successors. It accepts one request at a time over a valid/ready handshake and supports all RV32I load/store widths (LB/LH/LW/LBU/LHU/SB/SH/SW). It inserts a configurable number of wait states, flags misaligned, out-of-range and illegal accesses, and clears its storage with a hardware sweep after reset.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, 4..4096.
- `WAIT_STATES`, 0: extra cycles between request accept and response; 0..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified (low byte/half used for SB/SH).
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_rdata` out 32: load result, sign/zero-extended; 0 for stores and errors.
- `rsp_err` out 1: access faulted; valid only with `rsp_valid`.

## Operation
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT:
  - A word counter clears `mem[cnt]` to 0 each cycle, from 0 to DEPTH_WORDS-1, then moves to IDLE.
  - `req_ready`=0 throughout.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture we/funct3/addr/wdata.
  - Go to WAIT if WAIT_STATES>0 (load wait counter with WAIT_STATES-1), otherwise go to RESP.
- WAIT: decrement the counter; at 0, go to RESP.
- Access commit:
  - The memory read or write happens on the edge that enters RESP.
  - `rsp_rdata` and `rsp_err` are registered on that edge.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response back-pressure.
- Error checks, evaluated on the captured request; `rsp_err`=1 if any holds:
  - funct3 is 011, 110 or 111, or a store uses funct3 100 or 101;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error: no memory write, `rsp_rdata`=0.
- Stores merge byte lanes. Lane = addr[1:0] for SB and addr[1] selects the half for SH. Untouched bytes are preserved.
- Loads select the lane by address, then extend: funct3[2]=0 sign-extends, funct3[2]=1 zero-extends.
- Word index = addr[$clog2(DEPTH_WORDS)+1:2]. Higher address bits are used only in the range check and never wrap.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state INIT, counters 0.
- After `reset` deasserts, `req_ready` first rises DEPTH_WORDS cycles later.
- Latency: `rsp_valid` is high WAIT_STATES+1 cycles after the accept cycle.
- Throughput: one request per WAIT_STATES+2 cycles.
- `req_valid` held while `req_ready`=0 is ignored. The requester holds its request until it is accepted.
- Reset in any state, including WAIT: the in-flight request is dropped with no write and no response, and the block returns to INIT and re-sweeps.
- Reset in the same cycle as the commit edge: reset wins and no write occurs.
- `req_valid` during RESP is not accepted until the following IDLE cycle.

## Structure
- Package `dmem_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encoding;
  - an `is_legal_access` function.
- Sub-module `dmem_lane_align`: combinational. Builds the store byte-enable and merged write word, and extracts and extends the load value. It is shared by the write and read paths.
- Top level: FSM, counters, request capture register, storage array.

## Test plan
- Init sweep: fill the memory, pulse reset, wait until `req_ready`=1 (DEPTH_WORDS cycles); LW at 0x0 and at 0xFC both return 0.
- Byte lanes:
  - SW 0x11223344 @0x8, then SB 0xAA @0xA, then LW @0x8 -> 0x11AA3344;
  - LB @0xA -> 0xFFFFFFAA;
  - LBU -> 0x000000AA.
- Halfwords:
  - SH 0x8001 @0x6 -> LH @0x6 = 0xFFFF8001 and LHU @0x6 = 0x00008001;
  - LW @0x4 -> upper half 0x8001, lower half unchanged.
- Faults:
  - LW @0x2 -> `rsp_err`=1, rdata 0;
  - SW @0x100 with DEPTH_WORDS=64 -> `rsp_err`=1 and memory unchanged;
  - funct3=011 -> `rsp_err`=1.
- Wait states, WAIT_STATES=3:
  - accept at cycle N -> `rsp_valid` at N+4 only;
  - `req_ready` low from N+1 through N+4;
  - back-to-back requests are spaced 5 cycles apart.
- Reset mid-operation: SW 0xDEADBEEF @0x0 with WAIT_STATES=3, reset in the first WAIT cycle -> no `rsp_valid`, INIT sweep repeats, LW @0x0 = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_lsu slice.
//   - RV32I load/store funct3 codes
//   - FSM state encoding
//   - captured request record
//   - is_legal_access(): fault check applied to a captured request
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // 1 when the access has a defined width for its direction, is naturally
  // aligned and its word index lies inside the array (no wrap-around).
  function automatic logic is_legal_access(input logic we, input logic [2:0] f3,
                                           input logic [31:0] addr,
                                           input int unsigned depth);
    logic ok;
    ok = 1'b1;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr[0];
      F3_W:    ok = (addr[1:0] == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && !addr[0];
      default: ok = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= depth) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 32-bit word.
//   funct3 : access width / extension
//   lane   : addr[1:0] of the access
//   wdata  : right-justified store data
//   rword  : current contents of the addressed word
//   wword  : rword with the store's bytes merged in
//   rdata  : load value, lane-selected and sign/zero-extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [3:0]  be;
  logic [31:0] sdata;
  logic [31:0] shifted;

  // Store data is replicated across lanes so each enabled byte sees its value.
  always_comb begin
    be    = 4'b1111;
    sdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        sdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        sdata = {2{wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        sdata = wdata;
      end
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wword[8*i +: 8] = be[i] ? sdata[8*i +: 8] : rword[8*i +: 8];
  end

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    case (funct3[1:0])
      2'b00:   rdata = funct3[2] ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   rdata = funct3[2] ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressable data memory behind an RV32I load/store port.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (one outstanding request)
//   req_we/funct3/addr/wdata : request fields
//   rsp_valid             : one-cycle response strobe
//   rsp_rdata / rsp_err   : load result / fault flag, registered at commit
// After reset the array is cleared by a one-word-per-cycle sweep before the
// port opens. WAIT_STATES adds cycles between accept and commit.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [AW-1:0] cnt;
  logic [3:0]  wcnt;
  lsu_req_t    cap;
  lsu_req_t    acc;
  logic [31:0] mem [DEPTH_WORDS];

  logic          commit;
  logic          acc_ok;
  logic [AW-1:0] acc_idx;
  logic [31:0]   wword;
  logic [31:0]   lval;

  // With no wait states the access commits on the accept edge, so the live
  // request is used; otherwise the captured copy drives the access.
  assign acc = (state == S_IDLE) ? lsu_req_t'{we: req_we, funct3: req_funct3,
                                               addr: req_addr, wdata: req_wdata}
                                 : cap;
  assign commit = (state == S_IDLE) ? (req_valid && (WAIT_STATES == 0))
                                    : ((state == S_WAIT) && (wcnt == 4'd0));
  assign acc_ok  = is_legal_access(acc.we, acc.funct3, acc.addr, DEPTH_WORDS);
  assign acc_idx = acc.addr[AW+1:2];

  dmem_lane_align u_align (
    .funct3 (acc.funct3),
    .lane   (acc.addr[1:0]),
    .wdata  (acc.wdata),
    .rword  (mem[acc_idx]),
    .wword  (wword),
    .rdata  (lval)
  );

  // Storage has no reset of its own; the INIT sweep clears it. A reset on the
  // commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_INIT)
        mem[cnt] <= '0;
      else if (commit && acc.we && acc_ok)
        mem[acc_idx] <= wword;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      cnt       <= '0;
      wcnt      <= '0;
      cap       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (commit) begin
        rsp_err   <= !acc_ok;
        rsp_rdata <= (acc_ok && !acc.we) ? lval : '0;
      end
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH_WORDS - 1)) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            cap       <= acc;
            req_ready <= 1'b0;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              wcnt  <= WAIT_LD;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (wcnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed, table-driven check of dmem_lsu (DEPTH 64, 3 wait states).
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int WS    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns negedges counted until req_ready is seen.
  task automatic count_to_ready(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 500);
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e,
                      output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    rd  = 'x;
    e   = 1'bx;
    lat = -1;
    if (!req_ready) begin
      check("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    rd = rsp_rdata;
    e  = rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n;
    logic        seen;
    logic [10:0] rv, vv, rv_exp, vv_exp;

    // Power-up sweep, then dirty a couple of words.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_to_ready(n);
    check("first_init_cycles", 32'(n), 32'(DEPTH));
    xact(1'b1, F3_W, 32'h0,  32'h12345678, rd, e, lat);
    xact(1'b1, F3_W, 32'hFC, 32'h9ABCDEF0, rd, e, lat);
    xact(1'b0, F3_W, 32'hFC, 32'h0, rd, e, lat);
    check("fill_readback", rd, 32'h9ABCDEF0);

    // Reset pulse: outputs clear, sweep takes DEPTH cycles.
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err",   32'(rsp_err),   32'd0);
    reset = 1'b0;
    count_to_ready(n);
    check("init_cycles", 32'(n), 32'(DEPTH));

    vecs.push_back('{"lw_0_swept",   1'b0, F3_W,  32'h00, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{"lw_fc_swept",  1'b0, F3_W,  32'hFC, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{"sw_8",         1'b1, F3_W,  32'h08, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{"sb_a",         1'b1, F3_B,  32'h0A, 32'hFFFFFFAA, 32'h0,        1'b0});
    vecs.push_back('{"lw_8_merged",  1'b0, F3_W,  32'h08, 32'h0,        32'h11AA3344, 1'b0});
    vecs.push_back('{"lb_a",         1'b0, F3_B,  32'h0A, 32'h0,        32'hFFFFFFAA, 1'b0});
    vecs.push_back('{"lbu_a",        1'b0, F3_BU, 32'h0A, 32'h0,        32'h000000AA, 1'b0});
    vecs.push_back('{"sh_6",         1'b1, F3_H,  32'h06, 32'h12348001, 32'h0,        1'b0});
    vecs.push_back('{"lh_6",         1'b0, F3_H,  32'h06, 32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{"lhu_6",        1'b0, F3_HU, 32'h06, 32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{"lw_4",         1'b0, F3_W,  32'h04, 32'h0,        32'h80010000, 1'b0});
    vecs.push_back('{"lw_mis_2",     1'b0, F3_W,  32'h02, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"sw_oor_100",   1'b1, F3_W,  32'h100, 32'h55555555, 32'h0,       1'b1});
    vecs.push_back('{"lw_0_nowrap",  1'b0, F3_W,  32'h00, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{"f3_011",       1'b0, 3'b011, 32'h00, 32'h0,       32'h0,        1'b1});
    vecs.push_back('{"sbu_illegal",  1'b1, F3_BU, 32'h0C, 32'h77,       32'h0,        1'b1});
    vecs.push_back('{"lh_mis_5",     1'b0, F3_H,  32'h05, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"sb_3",         1'b1, F3_B,  32'h03, 32'h00000080, 32'h0,        1'b0});
    vecs.push_back('{"lb_3",         1'b0, F3_B,  32'h03, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"lw_0_b3",      1'b0, F3_W,  32'h00, 32'h0,        32'h80000000, 1'b0});
    vecs.push_back('{"sw_fc",        1'b1, F3_W,  32'hFC, 32'hCAFEF00D, 32'h0,        1'b0});
    vecs.push_back('{"lhu_fe",       1'b0, F3_HU, 32'hFE, 32'h0,        32'h0000CAFE, 1'b0});
    vecs.push_back('{"lw_big_oor",   1'b0, F3_W,  32'h80000000, 32'h0,  32'h0,        1'b1});

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, lat);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_err"},   32'(e), 32'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"},   32'(lat), 32'(WS + 1));
    end

    // Back-to-back: hold req_valid; accepts every WS+2 cycles.
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h8; req_wdata = '0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      rv[i] = req_ready;
      vv[i] = rsp_valid;
      rv_exp[i] = (i % (WS + 2)) == 0;
      vv_exp[i] = (i % (WS + 2)) == (WS + 1);
      if (i == 9) req_valid = 1'b0;
    end
    check("b2b_ready_pattern", 32'(rv), 32'(rv_exp));
    check("b2b_valid_pattern", 32'(vv), 32'(vv_exp));

    // Reset in the first WAIT cycle: no response, full re-sweep, no write.
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    seen = rsp_valid;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = seen | rsp_valid;
    end while (!req_ready && n < 500);
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_init_cycles", 32'(n), 32'(DEPTH));
    xact(1'b0, F3_W, 32'h0, 32'h0, rd, e, lat);
    check("midrst_lw_0", rd, 32'h0);
    xact(1'b0, F3_W, 32'h8, 32'h0, rd, e, lat);
    check("midrst_lw_8_swept", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
